shared_ram_ctrl: RTL and testbench
==================================

SHARED_RAM_CTRL -- requirements
Module: shared_ram_ctrl

Interface
REQ-001 SHALL have parameter word_width, default 4, RAM word width in bits.
REQ-002 SHALL have parameter address_width, default 3, RAM address width; depth = 2**address_width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cN_wr_req  input  1  client N (N=0,1) write request, held until acked.
REQ-006 SHALL have ports cN_wr_address / cN_wr_data  input  address_width / word_width  write address/data, stable while req high.
REQ-007 SHALL have ports cN_wr_ack  output  1  combinational; high in the cycle client N's write is accepted.
REQ-008 SHALL have ports cN_rd_req / cN_rd_address  input  1 / address_width  read request plus address, held until acked.
REQ-009 SHALL have ports cN_rd_ack  output  1  combinational; high in the cycle client N's read is accepted.
REQ-010 SHALL have ports cN_rd_valid / cN_rd_data  output  1 / word_width  registered read return to client N.
REQ-011 SHALL have port clear  input  1  single-cycle pulse requesting a memory clear.
REQ-012 SHALL have port busy  output  1  high while clearing; no acks issued.
REQ-013 SHALL have ports ram_wr_en / ram_wr_address / ram_wr_data  output  1 / address_width / word_width  registered RAM write port.
REQ-014 SHALL have ports ram_rd_address / ram_rd_data  output / input  address_width / word_width  RAM read port.

Function
REQ-015 Write and read ports SHALL be arbitrated independently, each by 2-way round-robin; a single requester is granted immediately.
REQ-016 On contention, grant SHALL go to the client not granted last on that port; pointer updates only on grant.
REQ-017 A request SHALL be accepted on the edge where req and ack are both high; at most one write and one read accepted per cycle.
REQ-018 An accepted write SHALL drive ram_wr_en=1 with its address/data for exactly the following cycle; otherwise ram_wr_en=0.
REQ-019 An accepted read SHALL drive ram_rd_address the following cycle; RAM data is sampled one cycle later into cN_rd_data with cN_rd_valid=1 for one cycle; total latency 2 cycles from accept; full throughput of one read per cycle.
REQ-020 The requesting client ID SHALL travel with each read through a 2-stage tag pipeline; rd_valid asserts only for that client.
REQ-021 No forwarding: a read accepted in the same cycle as a write to the same address SHALL return the old content; a read accepted one cycle later SHALL return the new data.
REQ-022 FSM states CLEAR and RUN: in CLEAR, addresses 0..2**address_width-1 SHALL be written with 0, one per cycle, busy=1, all acks 0; after the last address -> RUN.
REQ-023 In RUN, clear=1 SHALL enter CLEAR the next cycle; reads already accepted SHALL still complete and return data.
REQ-024 The clear address counter SHALL stop at the last address (no wrap); clear asserted during CLEAR SHALL be ignored.

Reset
REQ-025 On rst: acks 0, rd_valid 0, rd_data 0, ram_wr_en 0, all addresses/data 0, round-robin pointers favour client 0, in-flight reads discarded (no rd_valid).
REQ-026 After reset the FSM SHALL enter CLEAR with busy=1 when CLEAR_ON_RESET_EN is defined, otherwise RUN with busy=0.

Configuration
REQ-027 Macro CLEAR_ON_RESET_EN: defined -> clear FSM, counter and clear input functional as REQ-022..024; undefined -> no FSM, busy tied 0, clear ignored, permanently RUN.

Structure
REQ-028 Package shared_mem_pkg SHALL hold the client-ID type, NUM_CLIENTS=2, the CLEAR/RUN state enum and the read latency constant (2).
REQ-029 A sub-module rr_arbiter2 (2-way round-robin with grant pointer) SHALL be instantiated twice, for write and read.

Verification
REQ-030 Reset with CLEAR_ON_RESET_EN, depth 8: busy high 8 cycles, ram_wr_en=1 at addresses 0..7 data 0, then busy=0.
REQ-031 c0 and c1 write together (addr 2 data 5, addr 3 data 9) -> c0 acked first, c1 next cycle; RAM writes in that order.
REQ-032 Both clients read continuously -> acks alternate 0,1,0,1; each rd_valid 2 cycles after its ack with correct data.
REQ-033 Write addr 4 data A and read addr 4 accepted same cycle -> old value; read one cycle later -> A.
REQ-034 Assert rst with two reads in flight -> no rd_valid after reset, all outputs at reset values.
REQ-035 clear pulse in RUN with one read in flight -> read returns data, busy high for depth cycles, requests unacked until done.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types and constants for the two-client shared RAM controller
package shared_mem_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int RD_LATENCY  = 2;

  typedef logic [$clog2(NUM_CLIENTS)-1:0] client_id_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; the pointer remembers the last granted client
module rr_arbiter2
  import shared_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [NUM_CLIENTS-1:0] req_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output client_id_t             gnt_id_o
);

  client_id_t last_q, last_d;

  always_comb begin
    gnt_id_o = '0;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
    gnt_o  = {gnt_id_o, ~gnt_id_o} & {NUM_CLIENTS{en_i & (|req_i)}};
    last_d = (en_i && (|req_i)) ? gnt_id_o : last_q;
  end

  // Reset value 1 makes client 0 win the first contended grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shared_ram_ctrl.sv
// rtl/shared_ram_ctrl.sv - two-client shared RAM controller with arbitrated write/read ports
// Optional memory clear FSM enabled by macro CLEAR_ON_RESET_EN.
module shared_ram_ctrl
  import shared_mem_pkg::*;
#(
  parameter int word_width    = 4,
  parameter int address_width = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c0_wr_req,
  input  logic [address_width-1:0] c0_wr_address,
  input  logic [word_width-1:0]    c0_wr_data,
  output logic                     c0_wr_ack,
  input  logic                     c0_rd_req,
  input  logic [address_width-1:0] c0_rd_address,
  output logic                     c0_rd_ack,
  output logic                     c0_rd_valid,
  output logic [word_width-1:0]    c0_rd_data,
  input  logic                     c1_wr_req,
  input  logic [address_width-1:0] c1_wr_address,
  input  logic [word_width-1:0]    c1_wr_data,
  output logic                     c1_wr_ack,
  input  logic                     c1_rd_req,
  input  logic [address_width-1:0] c1_rd_address,
  output logic                     c1_rd_ack,
  output logic                     c1_rd_valid,
  output logic [word_width-1:0]    c1_rd_data,
  input  logic                     clear,
  output logic                     busy,
  output logic                     ram_wr_en,
  output logic [address_width-1:0] ram_wr_address,
  output logic [word_width-1:0]    ram_wr_data,
  output logic [address_width-1:0] ram_rd_address,
  input  logic [word_width-1:0]    ram_rd_data
);

  logic [NUM_CLIENTS-1:0]   wr_gnt, rd_gnt;
  client_id_t               wr_id, rd_id;
  logic                     arb_en;
  logic                     clr_we;
  logic [address_width-1:0] clr_addr;

  assign arb_en = ~busy & ~rst;

  rr_arbiter2 u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .req_i    ({c1_wr_req, c0_wr_req}),
    .gnt_o    (wr_gnt),
    .gnt_id_o (wr_id)
  );

  rr_arbiter2 u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .req_i    ({c1_rd_req, c0_rd_req}),
    .gnt_o    (rd_gnt),
    .gnt_id_o (rd_id)
  );

  assign c0_wr_ack = wr_gnt[0];
  assign c1_wr_ack = wr_gnt[1];
  assign c0_rd_ack = rd_gnt[0];
  assign c1_rd_ack = rd_gnt[1];

`ifdef CLEAR_ON_RESET_EN
  ctrl_state_e              state_q, state_d;
  logic [address_width-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Counter parks on the last address; clear requests inside CLEAR are dropped
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == {address_width{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    clr_we   = (state_q == ST_CLEAR);
    clr_addr = clr_addr_q;
    busy     = (state_q == ST_CLEAR);
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
  assign busy         = 1'b0;
`endif

  logic                     ram_wr_en_q, ram_wr_en_d;
  logic [address_width-1:0] ram_wr_address_q, ram_wr_address_d;
  logic [word_width-1:0]    ram_wr_data_q, ram_wr_data_d;
  logic [address_width-1:0] ram_rd_address_q, ram_rd_address_d;
  logic                     rd_s1_vld_q;
  client_id_t               rd_s1_id_q;
  logic [NUM_CLIENTS-1:0]   rd_valid_q, rd_valid_d;
  logic [word_width-1:0]    c0_rd_data_q, c1_rd_data_q;

  always_comb begin
    ram_wr_en_d      = 1'b0;
    ram_wr_address_d = '0;
    ram_wr_data_d    = '0;
    if (clr_we) begin
      ram_wr_en_d      = 1'b1;
      ram_wr_address_d = clr_addr;
    end else if (|wr_gnt) begin
      ram_wr_en_d      = 1'b1;
      ram_wr_address_d = (wr_id == 1'b1) ? c1_wr_address : c0_wr_address;
      ram_wr_data_d    = (wr_id == 1'b1) ? c1_wr_data : c0_wr_data;
    end
  end

  // Stage 1 carries the client tag alongside the RAM address; stage 2 steers the returned word
  always_comb begin
    ram_rd_address_d = ram_rd_address_q;
    if (|rd_gnt) begin
      ram_rd_address_d = (rd_id == 1'b1) ? c1_rd_address : c0_rd_address;
    end
    rd_valid_d = '0;
    if (rd_s1_vld_q) begin
      rd_valid_d[rd_s1_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_en_q      <= 1'b0;
      ram_wr_address_q <= '0;
      ram_wr_data_q    <= '0;
      ram_rd_address_q <= '0;
      rd_s1_vld_q      <= 1'b0;
      rd_s1_id_q       <= '0;
      rd_valid_q       <= '0;
      c0_rd_data_q     <= '0;
      c1_rd_data_q     <= '0;
    end else begin
      ram_wr_en_q      <= ram_wr_en_d;
      ram_wr_address_q <= ram_wr_address_d;
      ram_wr_data_q    <= ram_wr_data_d;
      ram_rd_address_q <= ram_rd_address_d;
      rd_s1_vld_q      <= |rd_gnt;
      rd_s1_id_q       <= rd_id;
      rd_valid_q       <= rd_valid_d;
      if (rd_valid_d[0]) c0_rd_data_q <= ram_rd_data;
      if (rd_valid_d[1]) c1_rd_data_q <= ram_rd_data;
    end
  end

  assign ram_wr_en      = ram_wr_en_q;
  assign ram_wr_address = ram_wr_address_q;
  assign ram_wr_data    = ram_wr_data_q;
  assign ram_rd_address = ram_rd_address_q;
  assign c0_rd_valid    = rd_valid_q[0];
  assign c1_rd_valid    = rd_valid_q[1];
  assign c0_rd_data     = c0_rd_data_q;
  assign c1_rd_data     = c1_rd_data_q;

endmodule

// File: tb/tb_shared_ram_ctrl.sv
// tb/tb_shared_ram_ctrl.sv - randomized self-checking bench for shared_ram_ctrl against a behavioural model
module tb_shared_ram_ctrl;

  localparam int WW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wreq [2];
  logic [AW-1:0] waddr [2];
  logic [WW-1:0] wdata [2];
  logic          rreq [2];
  logic [AW-1:0] raddr [2];
  logic          clear_r;

  logic          c0_wr_ack, c1_wr_ack, c0_rd_ack, c1_rd_ack;
  logic          c0_rd_valid, c1_rd_valid;
  logic [WW-1:0] c0_rd_data, c1_rd_data;
  logic          busy, ram_wr_en;
  logic [AW-1:0] ram_wr_address, ram_rd_address;
  logic [WW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  shared_ram_ctrl #(.word_width(WW), .address_width(AW)) dut (
    .clk(clk), .rst(rst),
    .c0_wr_req(wreq[0]), .c0_wr_address(waddr[0]), .c0_wr_data(wdata[0]), .c0_wr_ack(c0_wr_ack),
    .c0_rd_req(rreq[0]), .c0_rd_address(raddr[0]), .c0_rd_ack(c0_rd_ack),
    .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
    .c1_wr_req(wreq[1]), .c1_wr_address(waddr[1]), .c1_wr_data(wdata[1]), .c1_wr_ack(c1_wr_ack),
    .c1_rd_req(rreq[1]), .c1_rd_address(raddr[1]), .c1_rd_ack(c1_rd_ack),
    .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
    .clear(clear_r), .busy(busy),
    .ram_wr_en(ram_wr_en), .ram_wr_address(ram_wr_address), .ram_wr_data(ram_wr_data),
    .ram_rd_address(ram_rd_address), .ram_rd_data(ram_rd_data)
  );

  // Environment RAM: synchronous write, asynchronous read
  logic [WW-1:0] ram_q [DEPTH] = '{default: '0};
  always @(posedge clk) if (ram_wr_en) ram_q[ram_wr_address] <= ram_wr_data;
  assign ram_rd_data = ram_q[ram_rd_address];

  int            checks = 0;
  int            errors = 0;
  int            cyc;
  int            busy_cnt;
  bit            wlast, rlast;
  logic [WW-1:0] mmem [DEPTH];
  bit            exp_wen;
  logic [AW-1:0] exp_waddr;
  logic [WW-1:0] exp_wdata;
  bit            exp_rv [2][4];
  logic [WW-1:0] exp_rd [2][4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Contention goes to whoever was not granted last; a lone requester wins at once
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input bit last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  task automatic model_reset();
    wlast = 1'b1;
    rlast = 1'b1;
`ifdef CLEAR_ON_RESET_EN
    busy_cnt = DEPTH;
`else
    busy_cnt = 0;
`endif
    exp_wen = 1'b0;
    for (int s = 0; s < 4; s++) begin
      exp_rv[0][s] = 1'b0;
      exp_rv[1][s] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_acks"}, 32'({c1_rd_ack, c0_rd_ack, c1_wr_ack, c0_wr_ack}), 32'd0);
    check_eq({tag, "_rd_valid"}, 32'({c1_rd_valid, c0_rd_valid}), 32'd0);
    check_eq({tag, "_rd_data"}, 32'({c1_rd_data, c0_rd_data}), 32'd0);
    check_eq({tag, "_ram_wr"}, 32'({ram_wr_en, ram_wr_address, ram_wr_data}), 32'd0);
    check_eq({tag, "_ram_rd_addr"}, 32'(ram_rd_address), 32'd0);
  endtask

  // One clock of the reference: check outputs at negedge, advance the model, drop acked requests
  task automatic run_cycle();
    logic [1:0] gw, gr;
    logic [1:0] slot, nslot;
    bit         k;
    @(negedge clk);
    gw = (busy_cnt > 0) ? 2'b00 : rr_pick({wreq[1], wreq[0]}, wlast);
    gr = (busy_cnt > 0) ? 2'b00 : rr_pick({rreq[1], rreq[0]}, rlast);
    check_eq("busy", 32'(busy), 32'(busy_cnt > 0));
    check_eq("wr_ack", 32'({c1_wr_ack, c0_wr_ack}), 32'(gw));
    check_eq("rd_ack", 32'({c1_rd_ack, c0_rd_ack}), 32'(gr));
    check_eq("ram_wr_en", 32'(ram_wr_en), 32'(exp_wen));
    if (exp_wen) begin
      check_eq("ram_wr_address", 32'(ram_wr_address), 32'(exp_waddr));
      check_eq("ram_wr_data", 32'(ram_wr_data), 32'(exp_wdata));
    end
    slot  = 2'(cyc);
    nslot = 2'(cyc + 2);
    check_eq("c0_rd_valid", 32'(c0_rd_valid), 32'(exp_rv[0][slot]));
    check_eq("c1_rd_valid", 32'(c1_rd_valid), 32'(exp_rv[1][slot]));
    if (exp_rv[0][slot]) check_eq("c0_rd_data", 32'(c0_rd_data), 32'(exp_rd[0][slot]));
    if (exp_rv[1][slot]) check_eq("c1_rd_data", 32'(c1_rd_data), 32'(exp_rd[1][slot]));
    exp_rv[0][slot] = 1'b0;
    exp_rv[1][slot] = 1'b0;
    // Reads see memory before any write accepted in the same cycle
    if (gr != 2'b00) begin
      k = gr[1];
      exp_rv[k][nslot] = 1'b1;
      exp_rd[k][nslot] = mmem[raddr[k]];
      rlast = k;
    end
    exp_wen = 1'b0;
    if (busy_cnt > 0) begin
      exp_wen   = 1'b1;
      exp_waddr = AW'(DEPTH - busy_cnt);
      exp_wdata = '0;
      mmem[exp_waddr] = '0;
      busy_cnt--;
    end else begin
      if (gw != 2'b00) begin
        k = gw[1];
        exp_wen   = 1'b1;
        exp_waddr = waddr[k];
        exp_wdata = wdata[k];
        mmem[waddr[k]] = wdata[k];
        wlast = k;
      end
`ifdef CLEAR_ON_RESET_EN
      if (clear_r) busy_cnt = DEPTH;
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
    if (gw[0]) wreq[0] = 1'b0;
    if (gw[1]) wreq[1] = 1'b0;
    if (gr[0]) rreq[0] = 1'b0;
    if (gr[1]) rreq[1] = 1'b0;
    clear_r = 1'b0;
  endtask

  task automatic drive_random(input int pw, input int pr);
    for (int i = 0; i < 2; i++) begin
      if (!wreq[i[0]] && int'($urandom_range(0, 99)) < pw) begin
        wreq[i[0]]  = 1'b1;
        waddr[i[0]] = AW'($urandom_range(0, DEPTH - 1));
        wdata[i[0]] = WW'($urandom);
      end
      if (!rreq[i[0]] && int'($urandom_range(0, 99)) < pr) begin
        rreq[i[0]]  = 1'b1;
        raddr[i[0]] = AW'($urandom_range(0, DEPTH - 1));
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && (wreq[0] || wreq[1] || rreq[0] || rreq[1]); n++) run_cycle();
    check_eq({tag, "_drained"}, 32'({wreq[1], wreq[0], rreq[1], rreq[0]}), 32'd0);
    repeat (3) run_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
    cyc = 0;
    rst = 1'b1;
    clear_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wreq[i[0]] = 1'b1; waddr[i[0]] = '0; wdata[i[0]] = '0;
      rreq[i[0]] = 1'b1; raddr[i[0]] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    wreq[0] = 1'b0; wreq[1] = 1'b0; rreq[0] = 1'b0; rreq[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Power-up clear sweep (or immediate RUN without the clear feature)
    repeat (DEPTH + 2) run_cycle();

    // Simultaneous writes: client 0 first, client 1 the cycle after
    wreq[0] = 1'b1; waddr[0] = 3'd2; wdata[0] = 4'd5;
    wreq[1] = 1'b1; waddr[1] = 3'd3; wdata[1] = 4'd9;
    drain("dual_wr");

    // Continuous reads from both clients
    for (int n = 0; n < 10; n++) begin
      if (!rreq[0]) begin rreq[0] = 1'b1; raddr[0] = AW'(n); end
      if (!rreq[1]) begin rreq[1] = 1'b1; raddr[1] = AW'(n + 3); end
      run_cycle();
    end
    drain("dual_rd");

    // Same-cycle read of a freshly written address returns old data, next cycle returns new
    wreq[0] = 1'b1; waddr[0] = 3'd4; wdata[0] = 4'hA;
    rreq[1] = 1'b1; raddr[1] = 3'd4;
    run_cycle();
    rreq[1] = 1'b1; raddr[1] = 3'd4;
    run_cycle();
    drain("no_fwd");

    // Reset with two reads in flight
    rreq[0] = 1'b1; raddr[0] = 3'd2;
    run_cycle();
    rreq[1] = 1'b1; raddr[1] = 3'd3;
    run_cycle();
    rst = 1'b1;
    wreq[0] = 1'b1; rreq[1] = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    wreq[0] = 1'b0; rreq[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (DEPTH + 3) run_cycle();

    // Clear pulse with a read in flight, requests during the sweep, and a second pulse ignored
    rreq[0] = 1'b1; raddr[0] = 3'd5;
    run_cycle();
    clear_r = 1'b1;
    run_cycle();
    for (int n = 0; n < DEPTH + 4; n++) begin
      drive_random(50, 50);
      if (n == 3) clear_r = 1'b1;
      run_cycle();
    end
    drain("clear_run");

    // Randomized traffic with occasional clear pulses
    for (int n = 0; n < 400; n++) begin
      drive_random(60, 70);
      if ($urandom_range(0, 49) == 0) clear_r = 1'b1;
      run_cycle();
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
